// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding, digit limit
// and elaboration-time width helpers.
package bcd2bin_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Smallest output width that holds 10^n - 1.
  function automatic int min_bin_w(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return $clog2(p);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first,
// acc = acc*10 + d, with illegal-digit (>9) detection.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   ready,
  output logic                   done_tick,
  output logic [BIN_W-1:0]       bin,
  output logic                   err,
  output state_t                 dbg_state
);

  localparam int SW    = 4 * NDIGITS;
  localparam int EW    = BIN_W + 4;
  localparam int CNT_W = cnt_width(NDIGITS);

  if (NDIGITS < 1 || NDIGITS > 6) begin : g_bad_ndigits
    $error("bcd2bin_seq: NDIGITS must be in 1..6");
  end
  if (BIN_W < min_bin_w(NDIGITS)) begin : g_bad_bin_w
    $error("bcd2bin_seq: BIN_W too narrow for NDIGITS");
  end

  state_t             state, state_nxt;
  logic [SW-1:0]      sreg, sreg_nxt;
  logic [BIN_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               err_acc, err_acc_nxt;
  logic [BIN_W-1:0]   bin_nxt;
  logic               err_nxt;
  logic [3:0]         d;
  logic [EW-1:0]      acc_ext, mul;

  // Handshake: start is honoured only in a cycle where ready=1 (IDLE); it is
  // dropped otherwise. done_tick pulses for one cycle and bin/err are valid from
  // that cycle until the next done_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      bin     <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      err_acc <= err_acc_nxt;
      bin     <= bin_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    err_acc_nxt = err_acc;
    bin_nxt     = bin;
    err_nxt     = err;
    ready       = 1'b0;
    done_tick   = 1'b0;
    d           = sreg[SW-1 -: 4];
    acc_ext     = {4'b0000, acc};
    mul         = (acc_ext << 3) + (acc_ext << 1) + EW'(d);

    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          sreg_nxt    = bcd_in;
          acc_nxt     = '0;
          cnt_nxt     = CNT_W'(NDIGITS - 1);
          err_acc_nxt = 1'b0;
          state_nxt   = ST_CONV;
        end
      end
      ST_CONV: begin
        acc_nxt     = mul[BIN_W-1:0];
        sreg_nxt    = sreg << 4;
        err_acc_nxt = err_acc | (d > BCD_MAX);
        if (cnt == '0) begin
          // Publish on the edge entering DONE so bin/err line up with done_tick.
          state_nxt = ST_DONE;
          bin_nxt   = err_acc_nxt ? '0 : acc_nxt;
          err_nxt   = err_acc_nxt;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        done_tick = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule
